// File: rtl/regfile_pairs.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pairs
// Description : 8080-style byte register file with even/odd pair access,
//               multiple prioritised write ports, a pair inc/dec port and
//               registered 1-cycle reads with optional write-to-read bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_pairs #(
    parameter int         NREGS     = 8,
    parameter int         NRD       = 4,
    parameter int         NWR       = 2,
    parameter int         BYPASS    = 1,
    parameter logic [7:0] RESET_VAL = 8'h00,
    localparam int        AW        = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NRD*AW-1:0] raddr,
    input  logic [NRD-1:0]    rpair,
    output logic [NRD*16-1:0] rdata,
    input  logic [NWR-1:0]    wen,
    input  logic [NWR*AW-1:0] waddr,
    input  logic [NWR-1:0]    wpair,
    input  logic [NWR*16-1:0] wdata,
    input  logic              inc_en,
    input  logic              inc_dec,
    input  logic [AW-1:0]     inc_addr
);

    localparam logic [AW-1:0] c_lsb = AW'(1);

    logic [7:0]    r_regs  [NREGS];
    logic [7:0]    w_next  [NREGS];
    logic [7:0]    w_src   [NREGS];
    logic [15:0]   r_rdata [NRD];

    logic [AW-1:0] w_wa      [NWR];
    logic [AW-1:0] w_wa_even [NWR];
    logic [AW-1:0] w_wa_odd  [NWR];
    logic [AW-1:0] w_ra      [NRD];
    logic [AW-1:0] w_ra_even [NRD];
    logic [AW-1:0] w_ra_odd  [NRD];

    logic [AW-1:0] w_inc_hi;
    logic [AW-1:0] w_inc_lo;
    logic [15:0]   w_inc_old;
    logic [15:0]   w_inc_new;

    // Per-port address decode: raw byte address plus the even (high) and
    // odd (low) halves of the addressed pair.
    genvar gj;
    generate
        for (gj = 0; gj < NWR; gj++) begin : g_waddr
            assign w_wa[gj]      = waddr[gj*AW +: AW];
            assign w_wa_even[gj] = w_wa[gj] & ~c_lsb;
            assign w_wa_odd[gj]  = w_wa[gj] | c_lsb;
        end
        for (gj = 0; gj < NRD; gj++) begin : g_raddr
            assign w_ra[gj]      = raddr[gj*AW +: AW];
            assign w_ra_even[gj] = w_ra[gj] & ~c_lsb;
            assign w_ra_odd[gj]  = w_ra[gj] | c_lsb;
        end
    endgenerate

    // Inc/dec works on the pre-edge pair; 16-bit arithmetic gives the
    // low-to-high carry/borrow and the modulo wrap for free.
    assign w_inc_hi  = inc_addr & ~c_lsb;
    assign w_inc_lo  = inc_addr | c_lsb;
    assign w_inc_old = {r_regs[w_inc_hi], r_regs[w_inc_lo]};
    assign w_inc_new = inc_dec ? (w_inc_old - 16'd1) : (w_inc_old + 16'd1);

    // Next array contents: inc first, then write ports in ascending order so
    // later (higher-index) ports overwrite earlier ones byte by byte.
    always_comb begin
        w_next = r_regs;
        if (inc_en) begin
            w_next[w_inc_hi] = w_inc_new[15:8];
            w_next[w_inc_lo] = w_inc_new[7:0];
        end
        for (int j = 0; j < NWR; j++) begin
            if (wen[j]) begin
                if (wpair[j]) begin
                    w_next[w_wa_even[j]] = wdata[j*16+8 +: 8];
                    w_next[w_wa_odd[j]]  = wdata[j*16   +: 8];
                end else begin
                    w_next[w_wa[j]]      = wdata[j*16   +: 8];
                end
            end
        end
    end

    // Read source: post-edge contents when bypassing, pre-edge otherwise.
    generate
        if (BYPASS != 0) begin : g_bypass
            assign w_src = w_next;
        end else begin : g_no_bypass
            assign w_src = r_regs;
        end
    endgenerate

    // Register array update; reset discards same-cycle writes and inc.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NREGS; k++) begin
                r_regs[k] <= RESET_VAL;
            end
        end else begin
            r_regs <= w_next;
        end
    end

    // Registered read ports: byte reads zero-extend, pair reads put the even
    // register in the high byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NRD; i++) begin
                r_rdata[i] <= 16'h0000;
            end
        end else begin
            for (int i = 0; i < NRD; i++) begin
                if (rpair[i]) begin
                    r_rdata[i] <= {w_src[w_ra_even[i]], w_src[w_ra_odd[i]]};
                end else begin
                    r_rdata[i] <= {8'h00, w_src[w_ra[i]]};
                end
            end
        end
    end

    // Flatten read data onto the output bus.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < NRD; i++) begin
            rdata[i*16 +: 16] = r_rdata[i];
        end
    end

endmodule
`default_nettype wire
